// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM built-in self-test sequencer.
// Holds the FSM state encoding, default geometry and the saturating error counter.
package ram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;

    localparam int               ERR_W   = 6;
    localparam logic [ERR_W-1:0] ERR_SAT = 6'd63;

    // Increment that sticks at ERR_SAT instead of wrapping back to zero.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_SAT) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// Pin bundle between the BIST sequencer (master) and the single-port RAM (slave).
interface ram_bist_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    // Protocol: a transfer happens on every rising edge where ram_ena=1.
    // ram_wena=1 writes ram_wdata to ram_addr; ram_wena=0 reads ram_addr and
    // the slave presents the word on ram_rdata one cycle later. There is no
    // back-pressure: the RAM accepts one access per cycle unconditionally.
    logic              ram_ena;
    logic              ram_wena;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output ram_ena,
        output ram_wena,
        output ram_addr,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_ena,
        input  ram_wena,
        input  ram_addr,
        input  ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/ram_bist_pattern.sv
// Expected test word for an address: (addr + SEED) in phase 0, its complement in phase 1.
module ram_bist_pattern #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int SEED   = 1
) (
    input  logic              phase,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] base;

    always_comb begin
        base = DATA_W'(addr) + DATA_W'(SEED);
        word = phase ? ~base : base;
    end

endmodule

// File: rtl/ram_bist.sv
// BIST sequencer: writes then read-compares every RAM word with a pattern and its
// complement, reporting pass/fail, the first failing address and a saturating error count.
module ram_bist
    import ram_bist_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int SEED   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    ram_bist_if.master        ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W-1:0] err_addr,
    output logic [ERR_W-1:0]  err_count,
    output state_e            dbg_state,
    output logic              dbg_phase
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic              phase_q, phase_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              rd_valid_q, rd_valid_d;
    logic [ERR_W-1:0]  err_count_q, err_count_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              pass_q, pass_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] cmp_word;
    logic              mismatch;

    ram_bist_pattern #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .SEED  (SEED)
    ) u_wr_pattern (
        .phase(phase_q),
        .addr (addr_q),
        .word (wr_word)
    );

    ram_bist_pattern #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .SEED  (SEED)
    ) u_cmp_pattern (
        .phase(phase_q),
        .addr (rd_addr_q),
        .word (cmp_word)
    );

    assign mismatch = rd_valid_q && (ram.ram_rdata != cmp_word);

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        addr_d      = addr_q;
        err_count_d = err_count_q;
        err_addr_d  = err_addr_q;
        pass_d      = pass_q;

        // Track the read issued this cycle so its data can be checked next cycle.
        rd_valid_d = (state_q == ST_RD);
        rd_addr_d  = addr_q;

        if (mismatch) begin
            err_count_d = sat_inc(err_count_q);
            if (err_count_q == '0) begin
                err_addr_d = rd_addr_q;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    err_count_d = '0;
                    err_addr_d  = '0;
                    pass_d      = 1'b0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    state_d     = ST_WR;
                end
            end
            ST_WR: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                    state_d = ST_WR;
                end else begin
                    // Uses the count including this cycle's final compare.
                    pass_d  = (err_count_d == '0);
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_WR) || (state_d == ST_RD) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            phase_q     <= 1'b0;
            addr_q      <= '0;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
            err_count_q <= '0;
            err_addr_q  <= '0;
            pass_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            addr_q      <= addr_d;
            rd_addr_q   <= rd_addr_d;
            rd_valid_q  <= rd_valid_d;
            err_count_q <= err_count_d;
            err_addr_q  <= err_addr_d;
            pass_q      <= pass_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // RAM pins depend only on registered state, so start/rdata never reach them combinationally.
    always_comb begin
        ram.ram_ena   = (state_q == ST_WR) || (state_q == ST_RD);
        ram.ram_wena  = (state_q == ST_WR);
        ram.ram_addr  = ram.ram_ena ? addr_q : '0;
        ram.ram_wdata = (state_q == ST_WR) ? wr_word : '0;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
    assign dbg_state = state_q;
    assign dbg_phase = phase_q;

endmodule

// File: doc/ram_bist.md
# ram_bist

Built-in self-test sequencer for the 32 × 32-bit single-port RAM. It sits directly upstream of the RAM and owns its `ena`/`wena`/`addr`/`data_in` pins during a test. It consumes `data_out` and reports pass/fail, the first failing address and the error count. It runs two full write/read-compare passes, a true pattern and its complement, across all 32 addresses.

## Interface
- `ADDR_W`, 5: RAM address width; depth is 2^ADDR_W.
- `DATA_W`, 32: RAM word width.
- `SEED`, 1: pattern offset; the word for address a is a + SEED.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`  in  1: rising-edge clock, shared with the RAM.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: launches a test; sampled only in IDLE.
- `ram_ena`  out  1: to RAM `ena`.
- `ram_wena`  out  1: to RAM `wena` (1 = write).
- `ram_addr`  out  ADDR_W: to RAM `addr`.
- `ram_wdata`  out  DATA_W: to RAM `data_in`.
- `ram_rdata`  in  DATA_W: from RAM `data_out`; valid one cycle after a read address is presented with `ena`=1 and `wena`=0.
- `busy`  out  1: high from the first WR cycle through DRAIN of phase B.
- `done`  out  1: one-cycle pulse in FIN.
- `pass`  out  1: 1 when `err_count`==0; updated in FIN and held until the next start.
- `err_addr`  out  ADDR_W: address of the first mismatch in the run.
- `err_count`  out  6: number of mismatches, saturating at 63.

## Operation
- States are IDLE, WR, RD, DRAIN and FIN, plus a phase bit (0 = pattern A, 1 = pattern B).
- Expected word: A = addr + SEED, truncated to DATA_W. B = ~(addr + SEED).
- IDLE:
  - all RAM outputs are 0;
  - when `start`=1: clear `err_count`, `err_addr`, `pass` and the address counter; phase←0; go to WR.
- WR: `ram_ena`=1, `ram_wena`=1, `ram_wdata`=pattern(phase, addr). The address increments each cycle; after address 2^ADDR_W−1, addr wraps to 0 and the state goes to RD.
- RD: `ram_ena`=1, `ram_wena`=0. The address increments each cycle. A delayed address register (`addr_d`) and a valid flag track the outstanding read. After the last address, go to DRAIN.
- Compare: every cycle the valid flag is set, compare `ram_rdata` with pattern(phase, `addr_d`). On mismatch:
  - `err_count`+1, saturating at 63;
  - if this is the first error of the run, `err_addr`←`addr_d`.
- DRAIN: `ram_ena`=0; perform the final compare for the last address.
  - If phase=0: phase←1, go to WR.
  - If phase=1: go to FIN.
- FIN: `done`=1, `pass`←(`err_count`==0), then go to IDLE.
- `start` is ignored outside IDLE.
- RAM outputs are decoded from state/address registers only; there is no combinational path from `start` or `ram_rdata` to any output.

## Timing
- Cycle 0 is the edge that samples `start`. Sequence:
  - WR-A: cycles 1–32;
  - RD-A: cycles 33–64;
  - DRAIN-A: cycle 65;
  - WR-B: cycles 66–97;
  - RD-B: cycles 98–129;
  - DRAIN-B: cycle 130;
  - FIN (`done`=1): cycle 131.
- Total: 131 cycles from `start` to `done` at ADDR_W=5.
- Read latency is 1: the compare for the address issued in cycle n happens in cycle n+1.
- Reset values: state IDLE, phase 0, and `ram_ena`, `ram_wena`, `ram_addr`, `ram_wdata`, `busy`, `done`, `pass`, `err_addr`, `err_count` all 0.
- Reset mid-run: every output returns to 0 asynchronously and RAM contents are don't-care. The next `start` runs a full, clean test.
- `start` held high through FIN: there is no re-launch until IDLE. A new run begins on the first edge in IDLE where `start`=1.
- `err_count` at 63 stays at 63. `err_addr` never changes after the first error of a run.

## Structure
- `ram_bist_pkg` holds the state enum, the default ADDR_W/DATA_W, and the error-counter width (6) with its saturation value (63).
- Sub-module `ram_bist_pattern` is combinational: it maps (phase, addr) to the expected word. It is instantiated twice, once for the write data and once for the compare against `addr_d`.

## Test plan
- Fault-free RAM, pulse `start` → `done` at cycle 131, `pass`=1, `err_count`=0, and the RAM writes 1..32 then ~1..~32.
- RAM data bit 0 stuck-at-0 at address 7 only → `pass`=0, `err_addr`=7, `err_count`=1 (pattern A value 8 passes; pattern B ~8 fails).
- Address 31 aliased onto address 30 → mismatch at address 30 in each phase: `err_count`=2, `err_addr`=30.
- `ram_rdata` tied to 0 → 64 mismatches, so `err_count` saturates at 63; `err_addr`=0, `pass`=0.
- `rst` pulsed at cycle 40 → all outputs are 0 immediately and `ram_ena`=0. A new `start` on a fault-free RAM → `pass`=1 at cycle 131 after that start.
- `start` re-pulsed at cycles 10 and 100 of a run → ignored; a single `done` at cycle 131.
